rpn_operand_stack: RTL and testbench

Operand stack for the 8-bit RPN ALU. It holds pushed operands and, on an execute command, pops the top one or two entries and presents them as an `A`/`B` operand pair to the ALU operation units (AND/OR/XOR/NOT and arithmetic). It then waits for the ALU result and pushes it back as the new top of stack. It sits directly upstream of the ALU operation units, and the same unit also consumes their result.

---
 rtl/rpn_operand_stack.sv | 162 ++++++++++++++++
 tb/tb_rpn_operand_stack.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_operand_stack.sv
// rtl/rpn_operand_stack.sv - operand stack feeding A/B pairs to the RPN ALU and taking back its result

module rpn_operand_stack #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                din,
  input  logic                         pop,
  input  logic                         exec,
  input  logic                         unary,
  input  logic                         clear,
  output logic                         op_valid,
  output logic [DW-1:0]                op_a,
  output logic [DW-1:0]                op_b,
  input  logic                         res_valid,
  input  logic [DW-1:0]                res,
  output logic [DW-1:0]                top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         empty,
  output logic                         full,
  output logic                         busy,
  output logic                         err
);

  localparam int AW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   depth_q, depth_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic            err_q, err_d;

  // Entries above depth_q hold stale data; only the write port below changes them.
  logic [DW-1:0]   mem_q [DEPTH];

  logic            wr_en;
  logic [IW-1:0]   wr_idx;
  logic [DW-1:0]   wr_data;

  // Indices are taken modulo 2**IW; the true values always fit, so truncation is exact.
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   sec_idx;

  assign top_idx = IW'(depth_q) - IW'(1);
  assign sec_idx = IW'(depth_q) - IW'(2);

  // Combinational views derived from the occupancy count and the entries.
  always_comb begin
    empty = (depth_q == '0);
    full  = (depth_q == AW'(DEPTH));
    top   = empty ? '0 : mem_q[top_idx];
  end

  // Next-state logic: one command per cycle in IDLE, only clear/result in WAIT.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = IW'(depth_q);
    wr_data = din;

    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          depth_d = '0;
        end else if (exec) begin
          if (unary) begin
            if (depth_q >= AW'(1)) begin
              op_a_d  = mem_q[top_idx];
              op_b_d  = '0;
              depth_d = depth_q - AW'(1);
              state_d = S_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            if (depth_q >= AW'(2)) begin
              op_a_d  = mem_q[sec_idx];
              op_b_d  = mem_q[top_idx];
              depth_d = depth_q - AW'(2);
              state_d = S_WAIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (push) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            depth_d = depth_q + AW'(1);
          end
        end else if (pop) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            depth_d = depth_q - AW'(1);
          end
        end
      end

      S_WAIT: begin
        // An issued operation popped at least one entry, so the result always has room.
        if (clear) begin
          depth_d = '0;
          state_d = S_IDLE;
        end else if (res_valid) begin
          wr_en   = 1'b1;
          wr_data = res;
          depth_d = depth_q + AW'(1);
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and operand registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      err_q   <= err_d;
    end
  end

  // Entry storage write port; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign op_valid = (state_q == S_WAIT);
  assign busy     = (state_q == S_WAIT);
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign depth    = depth_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rpn_operand_stack.sv
// tb/tb_rpn_operand_stack.sv - scoreboard bench for rpn_operand_stack

module tb_rpn_operand_stack;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] din;
  logic       pop;
  logic       exec;
  logic       unary;
  logic       clear;
  logic       op_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       res_valid;
  logic [7:0] res;
  logic [7:0] top;
  logic [2:0] depth;
  logic       empty;
  logic       full;
  logic       busy;
  logic       err;

  rpn_operand_stack #(.DEPTH(4), .DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .din       (din),
    .pop       (pop),
    .exec      (exec),
    .unary     (unary),
    .clear     (clear),
    .op_valid  (op_valid),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res       (res),
    .top       (top),
    .depth     (depth),
    .empty     (empty),
    .full      (full),
    .busy      (busy),
    .err       (err)
  );

  typedef struct {
    int         cyc;
    logic [2:0] depth;
    logic [7:0] top;
    logic       opv;
    logic [7:0] a;
    logic [7:0] b;
    logic       err;
    logic       chk_ops;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_n    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc_n, act, exp_v);
    end
  endfunction

  // Monitor: at each falling edge compare the DUT against the record due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_n) begin
      exp_t e;
      e = sb.pop_front();
      if (e.cyc < cyc_n) begin
        chk("stale_record", 16'(e.cyc), 16'(cyc_n));
      end else begin
        chk("depth", 16'(depth), 16'(e.depth));
        chk("top", 16'(top), 16'(e.top));
        chk("empty", 16'(empty), 16'(e.depth == 3'd0));
        chk("full", 16'(full), 16'(e.depth == 3'd4));
        chk("op_valid", 16'(op_valid), 16'(e.opv));
        chk("busy", 16'(busy), 16'(e.opv));
        chk("err", 16'(err), 16'(e.err));
        if (e.opv || e.chk_ops) begin
          chk("op_a", 16'(op_a), 16'(e.a));
          chk("op_b", 16'(op_b), 16'(e.b));
        end
      end
    end
  end

  // Drive one cycle of inputs, then queue the state expected after the sampling edge.
  task automatic step(input logic p, input logic [7:0] d, input logic po, input logic ex,
                      input logic un, input logic cl, input logic rv, input logic [7:0] r,
                      input logic [2:0] e_depth, input logic [7:0] e_top, input logic e_opv,
                      input logic [7:0] e_a, input logic [7:0] e_b, input logic e_err,
                      input logic e_chk_ops);
    exp_t e;
    push = p; din = d; pop = po; exec = ex; unary = un; clear = cl;
    res_valid = rv; res = r;
    @(posedge clk);
    #1;
    e.cyc = cyc_n; e.depth = e_depth; e.top = e_top; e.opv = e_opv;
    e.a = e_a; e.b = e_b; e.err = e_err; e.chk_ops = e_chk_ops;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [2:0] e_depth, input logic [7:0] e_top, input logic e_opv,
                      input logic [7:0] e_a, input logic [7:0] e_b);
    step(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, e_depth, e_top, e_opv, e_a, e_b, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    push = 0; din = 0; pop = 0; exec = 0; unary = 0; clear = 0; res_valid = 0; res = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    step(0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0, 1);

    // Binary operation.
    step(1, 8'h3C, 0, 0, 0, 0, 0, 8'h00, 3'd1, 8'h3C, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h0F, 0, 0, 0, 0, 0, 8'h00, 3'd2, 8'h0F, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h3C, 8'h0F, 0, 0);
    idle(3'd0, 8'h00, 1, 8'h3C, 8'h0F);
    step(0, 8'h00, 0, 0, 0, 0, 1, 8'h0C, 3'd1, 8'h0C, 0, 8'h00, 8'h00, 0, 0);

    // Unary operation.
    step(1, 8'hA5, 0, 0, 0, 0, 0, 8'h00, 3'd2, 8'hA5, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 3'd1, 8'h0C, 1, 8'hA5, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, 1, 8'h5A, 3'd2, 8'h5A, 0, 8'h00, 8'h00, 0, 0);

    // Clear, then overflow.
    step(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h11, 0, 0, 0, 0, 0, 8'h00, 3'd1, 8'h11, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h22, 0, 0, 0, 0, 0, 8'h00, 3'd2, 8'h22, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h33, 0, 0, 0, 0, 0, 8'h00, 3'd3, 8'h33, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h44, 0, 0, 0, 0, 0, 8'h00, 3'd4, 8'h44, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h55, 0, 0, 0, 0, 0, 8'h00, 3'd4, 8'h44, 0, 8'h00, 8'h00, 1, 0);
    idle(3'd4, 8'h44, 0, 8'h00, 8'h00);

    // Underflow.
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd3, 8'h33, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd2, 8'h22, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd1, 8'h11, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd0, 8'h00, 0, 8'h00, 8'h00, 1, 0);

    // Exec underflow with one entry.
    step(1, 8'h77, 0, 0, 0, 0, 0, 8'h00, 3'd1, 8'h77, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'd1, 8'h77, 0, 8'h00, 8'h00, 1, 0);

    // Commands ignored in WAIT; clear beats a same-cycle result.
    step(1, 8'h66, 0, 0, 0, 0, 0, 8'h00, 3'd2, 8'h66, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h77, 8'h66, 0, 0);
    step(1, 8'h99, 0, 0, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h77, 8'h66, 0, 0);
    step(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h77, 8'h66, 0, 0);
    step(0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h77, 8'h66, 0, 0);
    step(0, 8'h00, 0, 0, 0, 1, 1, 8'h12, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    idle(3'd0, 8'h00, 0, 8'h00, 8'h00);

    // Result returned in the first WAIT cycle.
    step(1, 8'h01, 0, 0, 0, 0, 0, 8'h00, 3'd1, 8'h01, 0, 8'h00, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'h01, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, 1, 8'hFE, 3'd1, 8'hFE, 0, 8'h00, 8'h00, 0, 0);

    // Priority: push over pop, exec over push.
    step(1, 8'h02, 1, 0, 0, 0, 0, 8'h00, 3'd2, 8'h02, 0, 8'h00, 8'h00, 0, 0);
    step(1, 8'h03, 0, 1, 0, 0, 0, 8'h00, 3'd0, 8'h00, 1, 8'hFE, 8'h02, 0, 0);

    // Asynchronous reset in WAIT, between edges.
    push = 0; pop = 0; exec = 0; unary = 0; clear = 0; res_valid = 0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_depth", 16'(depth), 16'd0);
    chk("async_op_valid", 16'(op_valid), 16'd0);
    chk("async_busy", 16'(busy), 16'd0);
    chk("async_op_a", 16'(op_a), 16'h00);
    chk("async_op_b", 16'(op_b), 16'h00);
    chk("async_top", 16'(top), 16'h00);
    chk("async_empty", 16'(empty), 16'd1);
    chk("async_full", 16'(full), 16'd0);
    chk("async_err", 16'(err), 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Normal push after reset; res_valid in IDLE is ignored.
    step(1, 8'h42, 0, 0, 0, 0, 0, 8'h00, 3'd1, 8'h42, 0, 8'h00, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1, 8'hEE, 3'd1, 8'h42, 0, 8'h00, 8'h00, 0, 1);
    idle(3'd1, 8'h42, 0, 8'h00, 8'h00);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
